// File: rtl/cache_rd_resp.sv
// rtl/cache_rd_resp.sv - cache miss read responder: latency wait, then 1- or 4-beat pipelined memory fetch.
// Optional macro CACHE_RESP_BUBBLE_EN inserts one idle cycle after each non-last beat.
module cache_rd_resp #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rd_req,
  input  logic [2:0]  rd_type,
  input  logic [31:0] rd_addr,
  output logic        rd_rdy,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] ret_data,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [1:0]  r_beat, w_beat_nx;
  logic [31:2] r_addr, w_addr_nx;
  logic [2:0]  r_type, w_type_nx;
`ifdef CACHE_RESP_BUBBLE_EN
  logic        r_gap, w_gap_nx;
`endif

  logic        w_line, w_last, w_mem_en, w_ret_valid, w_ret_last;
  logic [1:0]  w_k;
  logic        w_unused;

  assign w_unused = ^rd_addr[1:0];
  assign w_line   = (r_type == 3'b100);
  assign w_last   = !w_line || (r_beat == 2'd3);
  // Word index being fetched: beat 0 from WAIT, otherwise the beat after the one returning now.
  assign w_k      = (r_state == S_WAIT) ? 2'd0 : r_beat + 2'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_addr  <= '0;
      r_type  <= '0;
`ifdef CACHE_RESP_BUBBLE_EN
      r_gap   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_beat  <= w_beat_nx;
      r_addr  <= w_addr_nx;
      r_type  <= w_type_nx;
`ifdef CACHE_RESP_BUBBLE_EN
      r_gap   <= w_gap_nx;
`endif
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_beat_nx   = r_beat;
    w_addr_nx   = r_addr;
    w_type_nx   = r_type;
`ifdef CACHE_RESP_BUBBLE_EN
    w_gap_nx    = r_gap;
`endif
    w_mem_en    = 1'b0;
    w_ret_valid = 1'b0;
    w_ret_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_addr_nx  = rd_addr[31:2];
          w_type_nx  = rd_type;
          w_cnt_nx   = 4'(LAT);
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nx = r_cnt - 4'd1;
        end else begin
          w_mem_en   = 1'b1;
          w_beat_nx  = 2'd0;
          w_state_nx = S_BURST;
        end
      end
      S_BURST: begin
`ifdef CACHE_RESP_BUBBLE_EN
        if (r_gap) begin
          w_mem_en  = 1'b1;
          w_gap_nx  = 1'b0;
          w_beat_nx = r_beat + 2'd1;
        end else begin
          w_ret_valid = 1'b1;
          w_ret_last  = w_last;
          if (w_last) begin
            w_beat_nx  = 2'd0;
            w_state_nx = S_IDLE;
          end else begin
            w_gap_nx = 1'b1;
          end
        end
`else
        w_ret_valid = 1'b1;
        w_ret_last  = w_last;
        if (w_last) begin
          w_beat_nx  = 2'd0;
          w_state_nx = S_IDLE;
        end else begin
          w_mem_en  = 1'b1;
          w_beat_nx = r_beat + 2'd1;
        end
`endif
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign rd_rdy    = (r_state == S_IDLE);
  assign ret_valid = w_ret_valid;
  assign ret_last  = w_ret_last;
  assign ret_data  = w_ret_valid ? mem_rdata : 32'd0;
  assign mem_en    = w_mem_en;
  assign mem_addr  = !w_mem_en ? 32'd0 :
                     w_line    ? {r_addr[31:4], w_k, 2'b00} : {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_cache_rd_resp.sv
// tb/tb_cache_rd_resp.sv - randomized self-checking bench for cache_rd_resp against a cycle-schedule model.
module tb_cache_rd_resp;

  localparam int TB_LAT = 2;
`ifdef CACHE_RESP_BUBBLE_EN
  localparam int SP = 2;
`else
  localparam int SP = 1;
`endif
  localparam int MAXC = 4000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        rd_req = 1'b0;
  logic [2:0]  rd_type = 3'd0;
  logic [31:0] rd_addr = 32'd0;
  logic        rd_rdy, ret_valid, ret_last, mem_en;
  logic [31:0] ret_data, mem_addr;
  logic [31:0] mem_rdata = 32'd0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int free_cyc = 0;

  bit          exp_en   [0:MAXC];
  logic [31:0] exp_addr [0:MAXC];
  bit          exp_val  [0:MAXC];
  bit          exp_last [0:MAXC];

  cache_rd_resp #(.LAT(TB_LAT)) u_dut (
    .clk(clk), .resetn(resetn), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // A request accepted in cycle t fetches beat k at t+1+LAT+SP*k and returns it one cycle later.
  task automatic schedule(input int t, input logic [2:0] typ, input logic [31:0] addr);
    int nb;
    logic [31:0] base;
    nb   = (typ == 3'b100) ? 4 : 1;
    base = (typ == 3'b100) ? (addr & 32'hFFFF_FFF0) : (addr & 32'hFFFF_FFFC);
    for (int k = 0; k < nb; k++) begin
      int e;
      e = t + 1 + TB_LAT + SP * k;
      exp_en[e]       = 1'b1;
      exp_addr[e]     = base + 32'(4 * k);
      exp_val[e + 1]  = 1'b1;
      exp_last[e + 1] = (k == nb - 1);
    end
    free_cyc = t + 2 + TB_LAT + SP * (nb - 1) + 1;
  endtask

  task automatic check_cycle();
    chk("rd_rdy",    32'(rd_rdy),    32'(cyc >= free_cyc));
    chk("mem_en",    32'(mem_en),    32'(exp_en[cyc]));
    chk("mem_addr",  mem_addr,       exp_en[cyc] ? exp_addr[cyc] : 32'd0);
    chk("ret_valid", 32'(ret_valid), 32'(exp_val[cyc]));
    chk("ret_last",  32'(ret_last),  32'(exp_last[cyc]));
    chk("ret_data",  ret_data,       exp_val[cyc] ? mem_rdata : 32'd0);
  endtask

  task automatic step(input logic req, input logic [2:0] typ, input logic [31:0] addr);
    @(posedge clk);
    cyc++;
    #1;
    rd_req    = req;
    rd_type   = typ;
    rd_addr   = addr;
    mem_rdata = $urandom;
    @(negedge clk);
    check_cycle();
    if (req && cyc >= free_cyc) schedule(cyc, typ, addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_rdy"},    32'(rd_rdy),    32'd1);
    chk({tag, "_ret_valid"}, 32'(ret_valid), 32'd0);
    chk({tag, "_ret_last"},  32'(ret_last),  32'd0);
    chk({tag, "_ret_data"},  ret_data,       32'd0);
    chk({tag, "_mem_en"},    32'(mem_en),    32'd0);
    chk({tag, "_mem_addr"},  mem_addr,       32'd0);
  endtask

  // Reset asserted between edges: outputs must drop before any clock, and the burst is abandoned.
  task automatic mid_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    for (int i = cyc + 1; i <= MAXC; i++) begin
      exp_en[i] = 1'b0; exp_val[i] = 1'b0; exp_last[i] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    rd_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("held_rst");
    resetn = 1'b1;
    free_cyc = cyc + 1;
  endtask

  initial begin
    int t;
    for (int i = 0; i <= MAXC; i++) begin
      exp_en[i] = 1'b0; exp_addr[i] = 32'd0; exp_val[i] = 1'b0; exp_last[i] = 1'b0;
    end
    #1 resetn = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b1;
    #1 check_reset_outputs("por_req");
    rd_req = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Line read at 0x1C0C, ignored pulse at T+3, new single read at 0x103 at T+8.
    t = cyc + 1;
    step(1'b1, 3'b100, 32'h0000_1C0C);
    step(1'b0, 3'b000, 32'h0);
    step(1'b0, 3'b000, 32'h0);
    step(1'b1, 3'b100, 32'h0000_5550);
    while (cyc < t + 7) step(1'b0, 3'b000, 32'h0);
    step(1'b1, 3'b000, 32'h0000_0103);
    repeat (24) step(1'b0, 3'b000, 32'h0);

    // Reset during beat 1 of a line read.
    t = cyc + 1;
    step(1'b1, 3'b100, 32'h000A_BCD4);
    while (cyc < t + 2 + TB_LAT + SP) step(1'b0, 3'b000, 32'h0);
    chk("beat1_before_rst", 32'(ret_valid), 32'd1);
    mid_reset();
    repeat (12) step(1'b0, 3'b000, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      logic [2:0] typ;
      typ = ($urandom % 2 == 0) ? 3'b100 : 3'($urandom % 8);
      step(($urandom % 10) < 4, typ, $urandom);
    end
    repeat (30) step(1'b0, 3'b000, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
